// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: runs one I2C transaction (START, address byte, data
// bytes, STOP) by handshaking with the bit-level generators. It also muxes
// their open-drain drive requests onto the single SDA/SCL pad pair.
module i2c_txn_sequencer #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned MAX_LEN  = 255,
  localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [6:0]    i_cmd_addr,
  input  logic          i_cmd_rw,
  input  logic [LW-1:0] i_cmd_len,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  output logic [7:0]    o_rd_data,
  output logic          o_rd_valid,
  output logic          o_done,
  output logic          o_nack,
  output logic          o_busy,
  output logic          o_start_req,
  input  logic          i_start_done,
  output logic          o_stop_req,
  input  logic          i_stop_done,
  output logic          o_byte_req,
  input  logic          i_byte_done,
  output logic          o_byte_rw,
  output logic [7:0]    o_byte_data,
  output logic          o_byte_mack,
  input  logic [7:0]    i_byte_data,
  input  logic          i_byte_sack,
  input  logic          i_start_sda_drive,
  input  logic          i_start_scl_drive,
  input  logic          i_byte_sda_drive,
  input  logic          i_byte_scl_drive,
  input  logic          i_stop_sda_drive,
  input  logic          i_stop_scl_drive,
  output logic          o_sda_drive,
  output logic          o_scl_drive
);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, WRDATA, WRBYTE, RDBYTE, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] rem;
  logic          rw_q;
  logic          hold_sda, hold_scl;
  logic          accept, start_fire, byte_fire, stop_fire;
  logic          unused_clk_freq;

  // CLK_FREQ only documents the system clock; nothing is timed from it.
  assign unused_clk_freq = (CLK_FREQ != 0);

  // Handshake strobes: a done only counts while its own req is high.
  always_comb begin
    accept     = (state_q == IDLE) && i_cmd_valid;
    start_fire = o_start_req && i_start_done;
    byte_fire  = o_byte_req && i_byte_done;
    stop_fire  = o_stop_req && i_stop_done;
  end

  // State-decoded status and byte-generator controls.
  always_comb begin
    o_cmd_ready = (state_q == IDLE);
    o_busy      = (state_q != IDLE);
    o_wr_ready  = (state_q == WRDATA);
    o_byte_rw   = (state_q == RDBYTE);
    o_byte_mack = (state_q == RDBYTE) && (rem == LW'(1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (start_fire) state_d = ADDR;
      ADDR: begin
        if (byte_fire) begin
          if (i_byte_sack || rem == '0) state_d = STOP;
          else if (rw_q)                state_d = RDBYTE;
          else                          state_d = WRDATA;
        end
      end
      WRDATA: if (i_wr_valid) state_d = WRBYTE;
      WRBYTE: if (byte_fire && (i_byte_sack || rem == LW'(1))) state_d = STOP;
              else if (byte_fire) state_d = WRDATA;
      RDBYTE: if (byte_fire && rem == LW'(1)) state_d = STOP;
      STOP:   if (stop_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request registers. Byte/stop reqs follow the registered state, which
  // leaves one low cycle after every done (also between repeated reads);
  // the start req is raised on the accept edge itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_start_req <= 1'b0;
      o_byte_req  <= 1'b0;
      o_stop_req  <= 1'b0;
    end else begin
      o_start_req <= accept || ((state_q == START) && !start_fire);
      o_byte_req  <= ((state_q == ADDR) || (state_q == WRBYTE) ||
                      (state_q == RDBYTE)) && !byte_fire;
      o_stop_req  <= (state_q == STOP) && !stop_fire;
    end
  end

  // Command latch, byte counter, data path and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rem         <= '0;
      rw_q        <= 1'b0;
      o_nack      <= 1'b0;
      o_byte_data <= '0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      o_done     <= stop_fire;
      if (accept) begin
        rem         <= i_cmd_len;
        rw_q        <= i_cmd_rw;
        o_nack      <= 1'b0;
        o_byte_data <= {i_cmd_addr, i_cmd_rw};
      end
      if ((state_q == WRDATA) && i_wr_valid) o_byte_data <= i_wr_data;
      if (byte_fire) begin
        case (state_q)
          ADDR: if (i_byte_sack) o_nack <= 1'b1;
          WRBYTE: begin
            rem <= rem - LW'(1);
            if (i_byte_sack) o_nack <= 1'b1;
          end
          RDBYTE: begin
            rem        <= rem - LW'(1);
            o_rd_data  <= i_byte_data;
            o_rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Pad hold: remembers the drives seen when the last sub-block finished.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_sda <= 1'b1;
      hold_scl <= 1'b1;
    end else if (start_fire || byte_fire || stop_fire) begin
      hold_sda <= o_sda_drive;
      hold_scl <= o_scl_drive;
    end
  end

  // Pad mux: active sub-block passes through, otherwise the hold register.
  always_comb begin
    o_sda_drive = hold_sda;
    o_scl_drive = hold_scl;
    if (o_start_req) begin
      o_sda_drive = i_start_sda_drive;
      o_scl_drive = i_start_scl_drive;
    end else if (o_byte_req) begin
      o_sda_drive = i_byte_sda_drive;
      o_scl_drive = i_byte_scl_drive;
    end else if (o_stop_req) begin
      o_sda_drive = i_stop_sda_drive;
      o_scl_drive = i_stop_scl_drive;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: stub START/byte/STOP generators, a write-data
// feeder and a monitor; transactions come from a table of directed vectors.
module tb_i2c_txn_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_cmd_valid, o_cmd_ready;
  logic [6:0] i_cmd_addr;
  logic       i_cmd_rw;
  logic [7:0] i_cmd_len;
  logic [7:0] i_wr_data;
  logic       i_wr_valid, o_wr_ready;
  logic [7:0] o_rd_data;
  logic       o_rd_valid, o_done, o_nack, o_busy;
  logic       o_start_req, start_done, o_stop_req, stop_done, o_byte_req, byte_done;
  logic       o_byte_rw, o_byte_mack, byte_sack;
  logic [7:0] o_byte_data, byte_rdata;
  logic       st_sda, st_scl, by_sda, by_scl, sp_sda, sp_scl;
  logic       o_sda_drive, o_scl_drive;

  always #5 i_clk = ~i_clk;

  i2c_txn_sequencer #(.CLK_FREQ(25_000_000), .MAX_LEN(255)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_rw(i_cmd_rw), .i_cmd_len(i_cmd_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_done(o_done), .o_nack(o_nack), .o_busy(o_busy),
    .o_start_req(o_start_req), .i_start_done(start_done),
    .o_stop_req(o_stop_req), .i_stop_done(stop_done),
    .o_byte_req(o_byte_req), .i_byte_done(byte_done),
    .o_byte_rw(o_byte_rw), .o_byte_data(o_byte_data), .o_byte_mack(o_byte_mack),
    .i_byte_data(byte_rdata), .i_byte_sack(byte_sack),
    .i_start_sda_drive(st_sda), .i_start_scl_drive(st_scl),
    .i_byte_sda_drive(by_sda), .i_byte_scl_drive(by_scl),
    .i_stop_sda_drive(sp_sda), .i_stop_scl_drive(sp_scl),
    .o_sda_drive(o_sda_drive), .o_scl_drive(o_scl_drive)
  );

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] len;
    logic       sack_addr;
    logic       sack_data;
    logic [7:0] d0, d1, d2;   // write bytes, or bytes the slave returns
    int         gap;          // ready cycles before the first write byte
    logic       junk;         // hold i_wr_valid high with garbage
    logic       redo;         // pulse i_cmd_valid again while busy
    int         exp_bytes;
    logic       exp_nack;
    int         exp_nrd;
    int         exp_nwr;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // shared stub / monitor state
  logic [7:0] op_q[$];
  logic [7:0] bl_data[$];
  logic       bl_rw[$];
  logic       bl_mack[$];
  logic [7:0] rd_log[$];
  logic [7:0] wr_q[$];
  logic [7:0] rv[3];
  logic       sack_addr, sack_data, feed_junk;
  int         byte_idx, wr_gap, gap_cnt;
  int         done_cnt, wr_acc, wr_ready_cyc, hold_viol, pt_viol, multi_viol, adj_viol;
  logic       nack_at_done, busy_at_done;
  logic [1:0] drv_at_done;
  logic [2:0] prev_req = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // START generator stub
  initial begin
    start_done = 1'b0; st_sda = 1'b1; st_scl = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      if (start_done) start_done = 1'b0;
      else if (o_start_req) begin
        op_q.push_back(8'h53);
        st_sda = 1'b0; st_scl = 1'b1;
        @(posedge i_clk); #1;
        st_scl = 1'b0; start_done = 1'b1;
      end
    end
  end

  // Byte generator stub: SCL ends low on the done cycle, released afterwards
  initial begin
    byte_done = 1'b0; by_sda = 1'b1; by_scl = 1'b1; byte_rdata = '0; byte_sack = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (byte_done) begin
        byte_done = 1'b0; by_sda = 1'b1; by_scl = 1'b1;
      end else if (o_byte_req) begin : b_serve
        int idx;
        op_q.push_back(8'h42);
        bl_data.push_back(o_byte_data);
        bl_rw.push_back(o_byte_rw);
        bl_mack.push_back(o_byte_mack);
        idx = byte_idx;
        byte_idx++;
        for (int k = 0; k < 3; k++) begin
          by_scl = k[0]; by_sda = ~k[0];
          @(posedge i_clk); #1;
        end
        by_scl = 1'b0; by_sda = 1'b0;
        byte_sack  = (idx == 0) ? sack_addr : sack_data;
        byte_rdata = (idx >= 1 && idx <= 3) ? rv[idx-1] : 8'h00;
        byte_done  = 1'b1;
      end
    end
  end

  // STOP generator stub
  initial begin
    stop_done = 1'b0; sp_sda = 1'b1; sp_scl = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      if (stop_done) stop_done = 1'b0;
      else if (o_stop_req) begin
        op_q.push_back(8'h50);
        sp_sda = 1'b0; sp_scl = 1'b1;
        @(posedge i_clk); #1;
        sp_sda = 1'b1; stop_done = 1'b1;
      end
    end
  end

  // Write-data feeder
  initial begin
    i_wr_valid = 1'b0; i_wr_data = '0;
    forever begin
      @(posedge i_clk); #1;
      if (feed_junk) begin
        i_wr_valid = 1'b1; i_wr_data = 8'hEE;
      end else if (i_wr_valid) begin
        i_wr_valid = 1'b0;
      end else if (o_wr_ready && wr_q.size() > 0) begin
        if (gap_cnt < wr_gap) gap_cnt++;
        else begin
          i_wr_valid = 1'b1; i_wr_data = wr_q.pop_front(); gap_cnt = 0;
        end
      end
    end
  end

  // Monitor, sampled on the falling edge
  initial begin
    forever begin : mon
      logic [2:0] reqv;
      @(negedge i_clk);
      reqv = {o_start_req, o_byte_req, o_stop_req};
      if ($countones(reqv) > 1) multi_viol++;
      if (reqv != 3'b000 && prev_req != 3'b000 && reqv != prev_req) adj_viol++;
      prev_req = reqv;
      if (o_start_req && (o_sda_drive !== st_sda || o_scl_drive !== st_scl)) pt_viol++;
      else if (o_byte_req && (o_sda_drive !== by_sda || o_scl_drive !== by_scl)) pt_viol++;
      else if (o_stop_req && (o_sda_drive !== sp_sda || o_scl_drive !== sp_scl)) pt_viol++;
      if (o_wr_ready) begin
        wr_ready_cyc++;
        if (o_scl_drive !== 1'b0 || o_busy !== 1'b1) hold_viol++;
        if (i_wr_valid) wr_acc++;
      end
      if (o_rd_valid) rd_log.push_back(o_rd_data);
      if (o_done) begin
        done_cnt++;
        nack_at_done = o_nack;
        busy_at_done = o_busy;
        drv_at_done  = {o_sda_drive, o_scl_drive};
      end
    end
  end

  task automatic run_cmd(input int id, input vec_t v);
    logic [7:0] wd[3];
    logic       ok;
    string      p;
    p = $sformatf("v%0d_", id);
    wd[0] = v.d0; wd[1] = v.d1; wd[2] = v.d2;
    op_q.delete(); bl_data.delete(); bl_rw.delete(); bl_mack.delete();
    rd_log.delete(); wr_q.delete();
    byte_idx = 0; sack_addr = v.sack_addr; sack_data = v.sack_data;
    rv[0] = v.d0; rv[1] = v.d1; rv[2] = v.d2;
    if (!v.rw) for (int i = 0; i < int'(v.len) && i < 3; i++) wr_q.push_back(wd[i]);
    wr_gap = v.gap; gap_cnt = 0; feed_junk = v.junk;
    done_cnt = 0; wr_acc = 0; wr_ready_cyc = 0; hold_viol = 0;
    pt_viol = 0; multi_viol = 0; adj_viol = 0;

    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1; i_cmd_addr = v.addr; i_cmd_rw = v.rw; i_cmd_len = v.len;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    chk({p, "accept_start_req"}, 32'(o_start_req), 32'd1);
    chk({p, "accept_cmd_ready"}, 32'(o_cmd_ready), 32'd0);
    chk({p, "accept_nack_clr"},  32'(o_nack), 32'd0);
    if (v.redo) begin
      repeat (3) @(posedge i_clk);
      #1 i_cmd_valid = 1'b1; i_cmd_addr = 7'h7F;
      @(posedge i_clk); #1 i_cmd_valid = 1'b0;
    end
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(posedge i_clk);
    repeat (4) @(posedge i_clk);
    #1 feed_junk = 1'b0;

    chk({p, "n_done"}, 32'(done_cnt), 32'd1);
    chk({p, "nack"}, 32'(nack_at_done), 32'(v.exp_nack));
    chk({p, "nack_held"}, 32'(o_nack), 32'(v.exp_nack));
    chk({p, "busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({p, "drv_at_done"}, 32'(drv_at_done), 32'd3);
    chk({p, "idle_ready"}, 32'(o_cmd_ready), 32'd1);
    chk({p, "n_bytes"}, 32'(bl_data.size()), 32'(v.exp_bytes));
    ok = (op_q.size() == v.exp_bytes + 2);
    if (ok) begin
      ok = (op_q[0] == 8'h53) && (op_q[op_q.size()-1] == 8'h50);
      for (int k = 1; k < op_q.size() - 1; k++) if (op_q[k] != 8'h42) ok = 1'b0;
    end
    chk({p, "order"}, 32'(ok), 32'd1);
    if (bl_data.size() > 0) begin
      chk({p, "addr_byte"}, 32'(bl_data[0]), 32'({v.addr, v.rw}));
      chk({p, "addr_rw"}, 32'(bl_rw[0]), 32'd0);
      chk({p, "addr_mack"}, 32'(bl_mack[0]), 32'd0);
    end
    for (int k = 1; k < bl_data.size() && k < 4; k++) begin
      chk($sformatf("%sbyte%0d_rw", p, k), 32'(bl_rw[k]), 32'(v.rw));
      if (!v.rw) chk($sformatf("%sbyte%0d_data", p, k), 32'(bl_data[k]), 32'(wd[k-1]));
      else       chk($sformatf("%sbyte%0d_mack", p, k), 32'(bl_mack[k]), 32'(k == int'(v.len)));
    end
    chk({p, "n_rd"}, 32'(rd_log.size()), 32'(v.exp_nrd));
    for (int i = 0; i < rd_log.size() && i < 3; i++)
      chk($sformatf("%srd%0d", p, i), 32'(rd_log[i]), 32'(wd[i]));
    chk({p, "n_wr_acc"}, 32'(wr_acc), 32'(v.exp_nwr));
    if (v.exp_nwr == 0) chk({p, "wr_ready_cycles"}, 32'(wr_ready_cyc), 32'd0);
    if (v.gap > 0) chk({p, "gap_held"}, 32'(wr_ready_cyc > v.gap), 32'd1);
    chk({p, "hold_viol"}, 32'(hold_viol), 32'd0);
    chk({p, "passthru_viol"}, 32'(pt_viol), 32'd0);
    chk({p, "multi_req"}, 32'(multi_viol), 32'd0);
    chk({p, "adjacent_req"}, 32'(adj_viol), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          addr   rw    len    sack_a sack_d d0     d1     d2     gap junk  redo  bytes nack  nrd nwr
    vecs[0] = '{7'h33, 1'b0, 8'd2, 1'b0, 1'b0, 8'hA5, 8'h5A, 8'h00, 0, 1'b0, 1'b1, 3, 1'b0, 0, 2};
    vecs[1] = '{7'h33, 1'b1, 8'd3, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 0, 1'b0, 1'b0, 4, 1'b0, 3, 0};
    vecs[2] = '{7'h50, 1'b0, 8'd2, 1'b1, 1'b0, 8'hA5, 8'h5A, 8'h00, 0, 1'b1, 1'b0, 1, 1'b1, 0, 0};
    vecs[3] = '{7'h2A, 1'b1, 8'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1, 1'b0, 0, 0};
    vecs[4] = '{7'h10, 1'b0, 8'd1, 1'b0, 1'b0, 8'hC3, 8'h00, 8'h00, 20, 1'b0, 1'b0, 2, 1'b0, 0, 1};
    vecs[5] = '{7'h33, 1'b0, 8'd3, 1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 0, 1'b0, 1'b0, 2, 1'b1, 0, 1};
    vecs[6] = '{7'h01, 1'b1, 8'd1, 1'b0, 1'b1, 8'h9C, 8'h00, 8'h00, 0, 1'b0, 1'b0, 2, 1'b0, 1, 0};

    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_rw = 1'b0; i_cmd_len = '0;
    feed_junk = 1'b0; wr_gap = 0; gap_cnt = 0; byte_idx = 0; sack_addr = 1'b0; sack_data = 1'b0;
    done_cnt = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_drives", 32'({o_sda_drive, o_scl_drive}), 32'd3);
    chk("rst_reqs", 32'({o_start_req, o_byte_req, o_stop_req}), 32'd0);
    chk("rst_flags", 32'({o_wr_ready, o_rd_valid, o_done, o_nack, o_byte_rw, o_byte_mack}), 32'd0);
    chk("rst_byte_data", 32'(o_byte_data), 32'd0);
    chk("rst_rd_data", 32'(o_rd_data), 32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 7; i++) run_cmd(i, vecs[i]);

    // reset asserted between clock edges while a write data byte is on the bus
    op_q.delete(); bl_data.delete(); bl_rw.delete(); bl_mack.delete(); wr_q.delete();
    byte_idx = 0; sack_addr = 1'b0; sack_data = 1'b0; wr_gap = 0; gap_cnt = 0;
    wr_q.push_back(8'hA5); wr_q.push_back(8'h5A);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1; i_cmd_addr = 7'h33; i_cmd_rw = 1'b0; i_cmd_len = 8'd2;
    @(posedge i_clk); #1 i_cmd_valid = 1'b0;
    for (int c = 0; c < 300 && !(o_byte_req && byte_idx >= 2); c++) begin
      @(posedge i_clk); #2;
    end
    chk("rst_mid_wrbyte_reached", 32'({o_byte_req, byte_idx >= 2}), 32'd3);
    #1 i_rst = 1'b1;
    #1;
    chk("rst_mid_reqs", 32'({o_start_req, o_byte_req, o_stop_req}), 32'd0);
    chk("rst_mid_drives", 32'({o_sda_drive, o_scl_drive}), 32'd3);
    chk("rst_mid_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (10) @(posedge i_clk);
    run_cmd(7, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Transaction-level controller for the I2C master. It accepts one command (7-bit address, direction, byte count) and sequences the bit-level generators: `i2c_start_gen`, `i2c_byte_gen` and `i2c_stop_gen`. It handles their req/done handshakes, streams write and read data, and owns the single open-drain drive pair that reaches the SDA/SCL pads. It sits between the thermal-camera register-access logic and the I2C generators.

## Interface
- CLK_FREQ, 25_000_000: system clock in Hz. Passed through for documentation only; no internal timing uses it.
- MAX_LEN, 255: maximum payload byte count. It sets the width of `i_cmd_len` as `$clog2(MAX_LEN+1)`.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake. Transfer occurs when both are high on a clock edge.
- i_cmd_addr  in  7  slave address.
- i_cmd_rw  in  1  direction: 0 = write, 1 = read.
- i_cmd_len  in  LW  payload bytes. 0 means address-only probe.
- i_wr_data / i_wr_valid / o_wr_ready  in/in/out  8/1/1  write-byte stream.
- o_rd_data / o_rd_valid  out  8/1  read byte plus a one-cycle strobe.
- o_done  out  1  one-cycle pulse when the STOP condition completes.
- o_nack  out  1  status of the last transaction. 1 means the slave NACKed. Valid from the `o_done` pulse until the next command is accepted.
- o_busy  out  1  high whenever the sequencer is not in IDLE.
- o_start_req / i_start_done  out/in  1  start generator handshake.
- o_stop_req / i_stop_done  out/in  1  stop generator handshake.
- o_byte_req / i_byte_done  out/in  1  byte generator handshake.
- o_byte_rw  out  1  byte direction: 0 = shift out `o_byte_data`, 1 = shift in.
- o_byte_data  out  8  byte to transmit.
- o_byte_mack  out  1  ACK bit the master sends on reads: 0 = ACK, 1 = NACK.
- i_byte_data  in  8  received byte.
- i_byte_sack  in  1  slave ACK bit on writes: 0 = ACK.
- i_{start,byte,stop}_sda_drive, i_{start,byte,stop}_scl_drive  in  1 each  sub-block drive requests. 1 = release, 0 = pull low.
- o_sda_drive / o_scl_drive  out  1  muxed pad drives, same encoding.

## Operation
- **Req protocol.** Each `o_*_req` is registered. It is raised on entry to the owning state and held high through the cycle in which the matching `i_*_done` is sampled high. It is low on the next cycle. At most one req is high at any time.
- **States:** IDLE, START, ADDR, WRDATA, WRBYTE, RDBYTE, STOP.
- **IDLE.** `o_cmd_ready`=1. On accept, the sequencer latches addr, rw and len into a down-counter `rem`, clears `o_nack`, and moves to START.
- **START.** On `i_start_done`, go to ADDR.
- **ADDR.** Drive `o_byte_data={addr,rw}` and `o_byte_rw`=0. On `i_byte_done`, the next state is:
  - `i_byte_sack`=1: set `o_nack` and go to STOP.
  - else `rem`=0: go to STOP.
  - else rw=0: go to WRDATA.
  - else rw=1: go to RDBYTE.
- **WRDATA.** `o_wr_ready`=1 (combinational in this state). When `i_wr_valid` is high, capture `i_wr_data` into `o_byte_data` and go to WRBYTE. Waiting is unbounded and the bus is held.
- **WRBYTE.** On done:
  - decrement `rem`.
  - If NACK: set `o_nack` and go to STOP.
  - Else if `rem`=0 after the decrement: go to STOP.
  - Else: go to WRDATA.
- **RDBYTE.** `o_byte_rw`=1 and `o_byte_mack=(rem==1)`. On done:
  - register `o_rd_data=i_byte_data` and pulse `o_rd_valid` on the following cycle.
  - decrement `rem`.
  - If `rem` is now 0, go to STOP; otherwise stay in RDBYTE, re-issuing the req after one low cycle.
- **STOP.** On `i_stop_done`, go to IDLE and pulse `o_done` on that same transition edge. `o_nack` keeps its value.
- **Drive mux.** While a req is high, `o_sda_drive`/`o_scl_drive` pass through that sub-block's drive inputs. On the cycle a done is sampled, the current passed-through values are captured into a hold register. While no req is high, the hold register drives the pads, so SCL stays low between bytes.
- **Async reset:** state = IDLE, all reqs = 0, `rem` = 0, hold = (1,1). Reset mid-transaction therefore releases the bus without a STOP; recovery is the caller's responsibility.

## Timing
Reset values of all outputs:
- `o_cmd_ready`=1 and `o_busy`=0.
- `o_sda_drive`=`o_scl_drive`=1.
- All of the following are 0: every req, `o_wr_ready`, `o_rd_valid`, `o_done`, `o_nack`, `o_byte_rw`, `o_byte_mack`, `o_byte_data`, `o_rd_data`.

Cycle-level behaviour:
- Command accept at edge N: `o_start_req` is high from N+1 and `o_cmd_ready` is low from N+1.
- Done sampled at edge N: the next owner's req is high from N+2. There is one idle cycle between consecutive reqs.
- Write bytes: `o_wr_ready` is high only in WRDATA. A valid that arrives while not ready is ignored.
- A `i_*_done` that arrives for a sub-block whose req is low is ignored.
- `i_cmd_valid` during busy is ignored; it is not queued.

## Test plan
1. **Write, len=2.** Command addr=0x33, rw=0; wr bytes 0xA5 then 0x5A; slave ACKs all. Required:
   - byte_data sequence 0x66, 0xA5, 0x5A, in order start→byte×3→stop.
   - one `o_done` pulse with `o_nack`=0.
   - `o_busy` falls with `o_done`.
2. **Read, len=3.** Command addr=0x33, rw=1; stub returns 0x11, 0x22, 0x33. Required:
   - three `o_rd_valid` pulses with those values.
   - `o_byte_mack` = 0, 0, 1.
   - `o_nack`=0.
3. **Address NACK.** Stub returns sack=1 on ADDR. Required: no data bytes, no `o_wr_ready`, STOP issued, `o_done` with `o_nack`=1.
4. **Probe.** len=0 with ACK. Required: start→addr→stop, `o_nack`=0, zero `o_rd_valid`/`o_wr_ready`.
5. **Bus hold between bytes.** Byte stub drives scl=0 on its last cycle, then 1 after done; delay `i_wr_valid` 20 cycles. Required: `o_scl_drive` stays 0 throughout the gap and `o_busy`=1.
6. **Reset mid-transaction.** Assert `i_rst` during WRBYTE. Required: all reqs 0, drives (1,1) and `o_cmd_ready`=1 immediately, without waiting for a clock edge. A new command after release runs normally.
